// File: rtl/opb_status_pkg.sv
// ============================================================================
// Module      : opb_status_pkg
// Description : Shared constants and types for the OPB status counter bank:
//               register word offsets, CTRL bit positions, bus FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package opb_status_pkg;

    // Byte offsets of the register words relative to the slave base address
    localparam logic [31:0] STICKY_OFFSET     = 32'h0000_0000;
    localparam logic [31:0] CTRL_OFFSET       = 32'h0000_0004;
    localparam logic [31:0] COUNT_BASE_OFFSET = 32'h0000_0008;

    // CTRL register bit positions
    localparam int CTRL_FREEZE_BIT    = 0;
    localparam int CTRL_CLEAR_ALL_BIT = 1;

    // Bus handshake states: ACK drives xferAck, HOLD blocks a lingering select
    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACK  = 2'd1,
        BUS_HOLD = 2'd2
    } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/status_event_counter.sv
// ============================================================================
// Module      : status_event_counter
// Description : Single-channel event counter with freeze, synchronous clear
//               and saturate-or-wrap behaviour; flags overflow for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module status_event_counter #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             freeze,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    logic at_max;
    logic count_en;

    assign at_max   = &count;
    assign count_en = inc && !freeze;

    // A clear on the same edge discards the event, so it cannot overflow either
    assign overflow = count_en && !clr && at_max;

    // Counter register: clear wins over counting; at all-ones hold or wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count_en) begin
            if (at_max) begin
                if (!SATURATE) begin
                    count <= '0;
                end
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/opb_status_counter_bank.sv
// ============================================================================
// Module      : opb_status_counter_bank
// Description : OPB slave exposing a bank of per-channel event counters,
//               sticky overflow flags (W1C) and a FREEZE/CLEAR_ALL control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opb_status_counter_bank
    import opb_status_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR  = 32'h0108_0F00,
    parameter logic [31:0] C_HIGHADDR  = 32'h0108_0FFF,
    parameter int          C_NUM_CH    = 8,
    parameter int          C_CNT_WIDTH = 32,
    parameter int          C_SATURATE  = 1
) (
    input  logic                OPB_Clk,
    input  logic                OPB_Rst_n,
    input  logic [0:31]         OPB_ABus,
    input  logic [0:3]          OPB_BE,
    input  logic [0:31]         OPB_DBus,
    input  logic                OPB_RNW,
    input  logic                OPB_select,
    input  logic                OPB_seqAddr,
    output logic [0:31]         Sl_DBus,
    output logic                Sl_xferAck,
    output logic                Sl_errAck,
    output logic                Sl_retry,
    output logic                Sl_toutSup,
    input  logic [C_NUM_CH-1:0] event_in
);

    // Bus vectors are MSB-first; plain assignment puts register bit n on
    // bus bit 31-n, which is exactly the required mapping.
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] offset;
    logic [31:0] read_mux;
    logic [31:0] rdata;

    logic in_window;
    logic start;
    logic wr;
    logic rd;
    logic sticky_hit;
    logic ctrl_hit;
    logic clear_all;

    logic [C_NUM_CH-1:0]                  count_hit;
    logic [C_NUM_CH-1:0]                  count_clr;
    logic [C_NUM_CH-1:0]                  overflow;
    logic [C_NUM_CH-1:0]                  sticky;
    logic [C_NUM_CH-1:0]                  w1c_mask;
    logic [C_NUM_CH-1:0][C_CNT_WIDTH-1:0] counts;
    logic                                 freeze;

    bus_state_t state;
    bus_state_t state_next;

    logic unused_inputs;

    assign addr   = OPB_ABus;
    assign wdata  = OPB_DBus;
    assign offset = addr - C_BASEADDR;

    assign in_window = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    // A transfer is accepted only from IDLE; reads sample and writes commit here
    assign start = (state == BUS_IDLE) && OPB_select && in_window;
    assign wr    = start && !OPB_RNW;
    assign rd    = start && OPB_RNW;

    assign sticky_hit = (offset[31:2] == STICKY_OFFSET[31:2]);
    assign ctrl_hit   = (offset[31:2] == CTRL_OFFSET[31:2]);
    assign clear_all  = wr && ctrl_hit && wdata[CTRL_CLEAR_ALL_BIT];
    assign w1c_mask   = (wr && sticky_hit) ? wdata[C_NUM_CH-1:0] : '0;

    assign Sl_xferAck = (state == BUS_ACK);
    assign Sl_DBus    = rdata;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Byte enables and sequential-address hints do not affect full-word access
    assign unused_inputs = ^{OPB_BE, OPB_seqAddr, wdata, offset[1:0]};

    for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
        assign count_hit[i] = (offset[31:2] == 30'((COUNT_BASE_OFFSET >> 2) + 32'(i)));
        assign count_clr[i] = clear_all || (wr && count_hit[i]);

        status_event_counter #(
            .WIDTH    (C_CNT_WIDTH),
            .SATURATE (C_SATURATE != 0)
        ) u_counter (
            .clk      (OPB_Clk),
            .rst_n    (OPB_Rst_n),
            .inc      (event_in[i]),
            .clr      (count_clr[i]),
            .freeze   (freeze),
            .count    (counts[i]),
            .overflow (overflow[i])
        );
    end

    // Bus FSM state register
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state <= BUS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus FSM next state: one ack cycle, then one dead cycle before re-arming
    always_comb begin
        state_next = state;
        unique case (state)
            BUS_IDLE: if (start) state_next = BUS_ACK;
            BUS_ACK:  state_next = BUS_HOLD;
            BUS_HOLD: state_next = BUS_IDLE;
            default:  state_next = BUS_IDLE;
        endcase
    end

    // Read multiplexer; unmapped in-window words read as zero
    always_comb begin
        read_mux = '0;
        if (sticky_hit) begin
            read_mux = 32'(sticky);
        end
        if (ctrl_hit) begin
            read_mux[CTRL_FREEZE_BIT] = freeze;
        end
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (count_hit[i]) begin
                read_mux = 32'(counts[i]);
            end
        end
    end

    // Read data is held only for the ack cycle and zero otherwise
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= read_mux;
        end else begin
            rdata <= '0;
        end
    end

    // FREEZE control bit
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            freeze <= 1'b0;
        end else if (wr && ctrl_hit) begin
            freeze <= wdata[CTRL_FREEZE_BIT];
        end
    end

    // Sticky overflow flags: a new overflow beats a same-edge write-1-to-clear
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            sticky <= '0;
        end else if (clear_all) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~w1c_mask) | overflow;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_opb_status_counter_bank.sv
// ============================================================================
// Module      : tb_opb_status_counter_bank
// Description : Directed self-checking bench; a saturating and a wrapping
//               4-bit instance share the bus and event stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_opb_status_counter_bank;

    localparam logic [31:0] BASE     = 32'h0108_0F00;
    localparam logic [31:0] HIGH     = 32'h0108_0FFF;
    localparam int          NCH      = 8;
    localparam logic [31:0] A_STICKY = BASE;
    localparam logic [31:0] A_CTRL   = BASE + 32'h4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [0:31]     abus;
    logic [0:3]      be;
    logic [0:31]     dbus_w;
    logic            rnw;
    logic            sel;
    logic            seq;
    logic [NCH-1:0]  ev;

    logic [0:31]     dbus_sat,  dbus_wrap;
    logic            ack_sat,   ack_wrap;
    logic            err_sat,   err_wrap;
    logic            retry_sat, retry_wrap;
    logic            tout_sat,  tout_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    opb_status_counter_bank #(
        .C_BASEADDR (BASE), .C_HIGHADDR (HIGH), .C_NUM_CH (NCH),
        .C_CNT_WIDTH (4), .C_SATURATE (1)
    ) dut_sat (
        .OPB_Clk (clk), .OPB_Rst_n (rst_n), .OPB_ABus (abus), .OPB_BE (be),
        .OPB_DBus (dbus_w), .OPB_RNW (rnw), .OPB_select (sel), .OPB_seqAddr (seq),
        .Sl_DBus (dbus_sat), .Sl_xferAck (ack_sat), .Sl_errAck (err_sat),
        .Sl_retry (retry_sat), .Sl_toutSup (tout_sat), .event_in (ev)
    );

    opb_status_counter_bank #(
        .C_BASEADDR (BASE), .C_HIGHADDR (HIGH), .C_NUM_CH (NCH),
        .C_CNT_WIDTH (4), .C_SATURATE (0)
    ) dut_wrap (
        .OPB_Clk (clk), .OPB_Rst_n (rst_n), .OPB_ABus (abus), .OPB_BE (be),
        .OPB_DBus (dbus_w), .OPB_RNW (rnw), .OPB_select (sel), .OPB_seqAddr (seq),
        .Sl_DBus (dbus_wrap), .Sl_xferAck (ack_wrap), .Sl_errAck (err_wrap),
        .Sl_retry (retry_wrap), .Sl_toutSup (tout_wrap), .event_in (ev)
    );

    function automatic logic [31:0] a_count(input int ch);
        return BASE + 32'h8 + 32'(4 * ch);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus transfer; evm pulses events on the same edge the transfer starts
    task automatic bus_xfer(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                            input logic [NCH-1:0] evm,
                            output logic [31:0] d_sat, output logic [31:0] d_wrap);
        int waited = 0;
        @(negedge clk);
        abus = a; rnw = rd; dbus_w = rd ? 32'h0 : wd; sel = 1'b1; ev = evm;
        @(negedge clk);
        ev = '0;
        while (!ack_sat && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        d_sat = 32'h0; d_wrap = 32'h0;
        if (!ack_sat) begin
            check("ack_timeout", 32'(ack_sat), 32'h1);
        end else begin
            d_sat  = dbus_sat;
            d_wrap = dbus_wrap;
            check("ack_both", 32'(ack_wrap), 32'h1);
        end
        sel = 1'b0; dbus_w = '0;
        @(negedge clk);
        check("ack_one_cycle", 32'({ack_sat, ack_wrap}), 32'h0);
        check("dbus_idle_zero", dbus_sat | dbus_wrap, 32'h0);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] ds, dw;
        bus_xfer(a, 1'b0, wd, '0, ds, dw);
    endtask

    task automatic bus_write_ev(input logic [31:0] a, input logic [31:0] wd,
                                input logic [NCH-1:0] evm);
        logic [31:0] ds, dw;
        bus_xfer(a, 1'b0, wd, evm, ds, dw);
    endtask

    task automatic expect_read(input string tag, input logic [31:0] a,
                               input logic [31:0] e_sat, input logic [31:0] e_wrap);
        logic [31:0] ds, dw;
        bus_xfer(a, 1'b1, 32'h0, '0, ds, dw);
        check({tag, "/sat"},  ds, e_sat);
        check({tag, "/wrap"}, dw, e_wrap);
    endtask

    // n consecutive event cycles on one channel
    task automatic pulse(input int ch, input int n);
        @(negedge clk);
        ev[ch] = 1'b1;
        repeat (n) @(negedge clk);
        ev = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] acks;
        rst_n = 1'b0; abus = '0; be = 4'hF; dbus_w = '0; rnw = 1'b1;
        sel = 1'b0; seq = 1'b0; ev = '0;
        repeat (3) @(negedge clk);
        check("reset_ack",  32'({ack_sat, ack_wrap}), 32'h0);
        check("reset_dbus", dbus_sat | dbus_wrap, 32'h0);
        check("tied_zero",  32'({err_sat, retry_sat, tout_sat, err_wrap, retry_wrap, tout_wrap}), 32'h0);
        rst_n = 1'b1;

        expect_read("reset_sticky", A_STICKY,   32'h0, 32'h0);
        expect_read("reset_ctrl",   A_CTRL,     32'h0, 32'h0);
        expect_read("reset_count0", a_count(0), 32'h0, 32'h0);

        // 20 events: saturating holds at 0xF, wrapping passes 16 and lands on 4
        pulse(2, 20);
        expect_read("sat20_count2", a_count(2), 32'hF, 32'h4);
        expect_read("sat20_sticky", A_STICKY,   32'h4, 32'h4);
        bus_write(A_STICKY, 32'h4);
        expect_read("w1c_sticky",   A_STICKY,   32'h0, 32'h0);
        expect_read("w1c_count2",   a_count(2), 32'hF, 32'h4);

        bus_write(A_CTRL, 32'h2);
        expect_read("clrall_ctrl",   A_CTRL,     32'h0, 32'h0);
        expect_read("clrall_count2", a_count(2), 32'h0, 32'h0);

        pulse(0, 17);
        expect_read("ev17_count0", a_count(0), 32'hF, 32'h1);
        expect_read("ev17_sticky", A_STICKY,   32'h1, 32'h1);
        bus_write(A_CTRL, 32'h2);
        expect_read("clrall_sticky", A_STICKY,   32'h0, 32'h0);
        expect_read("clrall_count0", a_count(0), 32'h0, 32'h0);

        // Freeze blocks counting, unfreeze resumes from the held value
        pulse(1, 2);
        bus_write(A_CTRL, 32'h1);
        expect_read("freeze_ctrl",   A_CTRL,     32'h1, 32'h1);
        pulse(1, 10);
        expect_read("frozen_count1", a_count(1), 32'h2, 32'h2);
        bus_write(A_CTRL, 32'h0);
        pulse(1, 3);
        expect_read("thawed_count1", a_count(1), 32'h5, 32'h5);

        // Event and counter write on the same edge: clear wins
        pulse(3, 5);
        expect_read("pre_clr_count3", a_count(3), 32'h5, 32'h5);
        bus_write_ev(a_count(3), 32'hDEAD_BEEF, 8'h08);
        expect_read("clr_wins_count3", a_count(3), 32'h0, 32'h0);
        pulse(3, 1);
        expect_read("post_clr_count3", a_count(3), 32'h1, 32'h1);

        // Overflow and W1C of the same sticky bit on one edge: set wins
        bus_write(A_CTRL, 32'h2);
        pulse(2, 15);
        expect_read("at_max_count2",  a_count(2), 32'hF, 32'hF);
        expect_read("at_max_sticky",  A_STICKY,   32'h0, 32'h0);
        bus_write_ev(A_STICKY, 32'h4, 8'h04);
        expect_read("set_wins_sticky", A_STICKY,   32'h4, 32'h4);
        expect_read("set_wins_count2", a_count(2), 32'hF, 32'h0);

        // Unmapped in-window word: reads 0, write has no effect
        bus_write(BASE + 32'h28, 32'hFFFF_FFFF);
        expect_read("unmapped_read",  BASE + 32'h28, 32'h0, 32'h0);
        expect_read("unmapped_count2", a_count(2),   32'hF, 32'h0);

        // Select held for six cycles: acks on the 1st and 4th cycle only
        @(negedge clk);
        abus = A_STICKY; rnw = 1'b1; sel = 1'b1; acks = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acks[i] = ack_sat;
        end
        sel = 1'b0;
        check("held_sel_acks", 32'(acks), 32'h09);
        @(negedge clk);
        check("held_sel_release", 32'(ack_sat), 32'h0);

        // Out-of-window write just below the base and read just above the top
        @(negedge clk);
        abus = BASE - 32'h100 + 32'h4; rnw = 1'b0; dbus_w = 32'h1; sel = 1'b1; acks = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            acks[i] = ack_sat | ack_wrap;
        end
        abus = HIGH + 32'h1; rnw = 1'b1;
        for (int i = 3; i < 6; i++) begin
            @(negedge clk);
            acks[i] = ack_sat | ack_wrap;
        end
        sel = 1'b0; dbus_w = '0;
        check("oow_no_ack", 32'(acks), 32'h0);
        expect_read("oow_ctrl", A_CTRL, 32'h0, 32'h0);

        // Reset asserted during the ack cycle clears everything immediately
        pulse(4, 6);
        bus_write(A_CTRL, 32'h1);
        @(negedge clk);
        abus = a_count(4); rnw = 1'b1; sel = 1'b1;
        @(negedge clk);
        check("mid_ack_up",   32'(ack_sat), 32'h1);
        check("mid_ack_data", dbus_sat, 32'h6);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ack",  32'({ack_sat, ack_wrap}), 32'h0);
        check("mid_rst_dbus", dbus_sat | dbus_wrap, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_held_no_ack", 32'({ack_sat, ack_wrap}), 32'h0);
        sel = 1'b0;
        rst_n = 1'b1;
        expect_read("post_rst_count4", a_count(4), 32'h0, 32'h0);
        expect_read("post_rst_sticky", A_STICKY,   32'h0, 32'h0);
        expect_read("post_rst_ctrl",   A_CTRL,     32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
